// File: rtl/riscv_uar.sv
// UART receiver: 2-flop synchronized rx, mid-bit sampling FSM, and a receive buffer.
// Define RISCV_UAR_FIFO_EN for a 4-entry FIFO; otherwise a single holding register.
module riscv_uar #(
  parameter int CLK_FREQ = 500_000_000,
  parameter int BAUD     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dOut,
  output logic       dOutValid,
  input  logic       dOutReady,
  output logic       frameErr,
  output logic       overrun
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shReg;
  logic          rxMeta, rxs;
  logic          expire, push, pop, full, accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxs    <= rxMeta;
    end
  end

  // Counter is loaded with the wait length; the sample happens on the edge where it reads 1.
  assign expire = (cnt == CW'(1));
  assign push   = (state == STOP) && expire && rxs;
  assign pop    = dOutValid && dOutReady;
  assign accept = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bitIdx   <= '0;
      shReg    <= '0;
      frameErr <= 1'b0;
    end else begin
      frameErr <= 1'b0;
      case (state)
        IDLE: if (!rxs) begin
          state <= START;
          cnt   <= CW'(CLKS_PER_BIT / 2);
        end
        START: if (expire) begin
          if (rxs) state <= IDLE;
          else begin
            state  <= DATA;
            cnt    <= CW'(CLKS_PER_BIT);
            bitIdx <= '0;
          end
        end else cnt <= cnt - CW'(1);
        DATA: if (expire) begin
          shReg  <= {rxs, shReg[7:1]};
          cnt    <= CW'(CLKS_PER_BIT);
          bitIdx <= bitIdx + 3'd1;
          if (bitIdx == 3'd7) state <= STOP;
        end else cnt <= cnt - CW'(1);
        STOP: if (expire) begin
          if (rxs) state <= IDLE;
          else begin
            frameErr <= 1'b1;
            state    <= WAIT_HIGH;
          end
        end else cnt <= cnt - CW'(1);
        WAIT_HIGH: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RISCV_UAR_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wrPtr, rdPtr;
  logic [2:0] count;

  assign full      = (count == 3'd4);
  assign dOutValid = (count != 3'd0);
  assign dOut      = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (accept) begin
        mem[wrPtr] <= shReg;
        wrPtr      <= wrPtr + 2'd1;
      end
      if (pop) rdPtr <= rdPtr + 2'd1;
      count <= count + 3'(accept) - 3'(pop);
    end
  end
`else
  logic [7:0] hold;
  logic       holdValid;

  assign full      = holdValid;
  assign dOutValid = holdValid;
  assign dOut      = hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      holdValid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun   <= push && full && !pop;
      if (accept) hold <= shReg;
      holdValid <= accept || (holdValid && !pop);
    end
  end
`endif
endmodule
